// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control encodings, flag indices and default width
package alu_pkg;
  localparam int ALU_WIDTH = 64;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;
  localparam int FLAG_OF = 0;
  localparam int FLAG_SF = 1;
  localparam int FLAG_ZF = 2;
endpackage

// File: rtl/alu_core_if.sv
// alu_core_if: operand/result bundle between execute stage (master) and ALU (slave)
interface alu_core_if #(parameter int WIDTH = alu_pkg::ALU_WIDTH) ();
  logic [1:0] control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic set_cc;
  logic [WIDTH-1:0] y;
  logic overflow;
  logic [2:0] flags;
  modport master (output control, a, b, set_cc, input y, overflow, flags);
  modport slave (input control, a, b, set_cc, output y, overflow, flags);
endinterface

// File: rtl/alu_addsub.sv
// alu_addsub: single shared adder; sub is a + ~b + 1 with signed overflow
module alu_addsub #(parameter int WIDTH = 64) (
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_overflow
);
  logic [WIDTH-1:0] w_b;
  assign w_b = i_b ^ {WIDTH{i_sub}};
  assign o_sum = i_a + w_b + {{(WIDTH-1){1'b0}}, i_sub};
  // inverted b makes the sub rule identical to the add rule
  assign o_overflow = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/alu_core.sv
// alu_core: Y86-64 ALU (add/sub/and/xor) with registered OF/SF/ZF condition codes
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  alu_core_if.slave bus
);
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf_as;
  logic [WIDTH-1:0] w_y;
  logic             w_ovf;
  logic [2:0]       r_flags;
  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_sub      (bus.control == ALU_SUB),
    .i_a        (bus.a),
    .i_b        (bus.b),
    .o_sum      (w_sum),
    .o_overflow (w_ovf_as)
  );
  always_comb begin
    w_y = bus.control == ALU_AND ? bus.a & bus.b :
          bus.control == ALU_XOR ? bus.a ^ bus.b : w_sum;
    w_ovf = bus.control[1] ? 1'b0 : w_ovf_as;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_flags <= '0;
    else if (bus.set_cc) begin
      r_flags[FLAG_OF] <= w_ovf;
      r_flags[FLAG_SF] <= w_y[WIDTH-1];
      r_flags[FLAG_ZF] <= w_y == '0;
    end
  assign bus.y = w_y;
  assign bus.overflow = w_ovf;
  assign bus.flags = r_flags;
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors with literal expectations plus a per-cycle arithmetic model
module tb_alu_core;
  import alu_pkg::*;
  localparam logic signed [64:0] MAXV = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] MINV = 65'sh1_8000_0000_0000_0000;
  localparam logic [63:0] PMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NMIN = 64'h8000_0000_0000_0000;
  logic clk = 0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  logic [2:0] m_flags;
  alu_core_if #(.WIDTH(64)) bus ();
  alu_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic void model(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] y, output logic ov);
    logic signed [64:0] full;
    full = c == ALU_ADD ? $signed({a[63], a}) + $signed({b[63], b}) :
                          $signed({a[63], a}) - $signed({b[63], b});
    if (c[1]) begin
      y = c[0] ? a ^ b : a & b;
      ov = 1'b0;
    end else begin
      y = full[63:0];
      ov = full > MAXV || full < MINV;
    end
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    logic [63:0] y;
    logic ov;
    if (!rst_n) m_flags <= 3'b000;
    else if (bus.set_cc) begin
      model(bus.control, bus.a, bus.b, y, ov);
      m_flags <= {y == 64'd0, y[63], ov};
    end
  end
  always @(negedge clk) begin
    logic [63:0] y;
    logic ov;
    model(bus.control, bus.a, bus.b, y, ov);
    check("model_y", bus.y, y);
    check("model_ovf", {63'd0, bus.overflow}, {63'd0, ov});
    check("model_flags", {61'd0, bus.flags}, {61'd0, m_flags});
  end
  task automatic apply(input string name, input logic [1:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic sc, input logic [63:0] ey, input logic eov, input logic [2:0] ef);
    bus.control = c;
    bus.a = a;
    bus.b = b;
    bus.set_cc = sc;
    #1;
    check({name, "_y"}, bus.y, ey);
    check({name, "_ovf"}, {63'd0, bus.overflow}, {63'd0, eov});
    @(posedge clk);
    #1;
    check({name, "_flags"}, {61'd0, bus.flags}, {61'd0, ef});
  endtask
  initial begin
    rst_n = 0;
    bus.control = ALU_ADD;
    bus.a = 0;
    bus.b = 0;
    bus.set_cc = 0;
    #1;
    check("reset_flags", {61'd0, bus.flags}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    apply("add_ovf", ALU_ADD, PMAX, 64'd1, 1, NMIN, 1, 3'b011);
    apply("sub_zero", ALU_SUB, 64'd5, 64'd5, 1, 64'd0, 0, 3'b100);
    apply("sub_neg", ALU_SUB, 64'd3, 64'd10, 1, 64'hFFFF_FFFF_FFFF_FFF9, 0, 3'b010);
    apply("sub_ovf", ALU_SUB, NMIN, 64'd1, 1, PMAX, 1, 3'b001);
    apply("and_zero", ALU_AND, 64'hF0F0, 64'h0F0F, 1, 64'd0, 0, 3'b100);
    apply("hold", ALU_ADD, 64'd1, 64'd1, 0, 64'd2, 0, 3'b100);
    apply("clear", ALU_ADD, 64'd1, 64'd1, 1, 64'd2, 0, 3'b000);
    apply("xor", ALU_XOR, 64'hF0F0, 64'h0F0F, 1, 64'hFFFF, 0, 3'b000);
    apply("xor_self", ALU_XOR, PMAX, PMAX, 1, 64'd0, 0, 3'b100);
    apply("add_neg1", ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'd0, 0, 3'b100);
    apply("add_min2", ALU_ADD, NMIN, NMIN, 1, 64'd0, 1, 3'b101);
    apply("sub_0_min", ALU_SUB, 64'd0, NMIN, 1, NMIN, 1, 3'b011);
    apply("sub_max_neg", ALU_SUB, PMAX, 64'hFFFF_FFFF_FFFF_FFFF, 1, NMIN, 1, 3'b011);
    apply("and_ovf0", ALU_AND, NMIN, NMIN, 1, NMIN, 0, 3'b010);
    apply("rsp_dec", ALU_SUB, 64'h100, 64'd8, 1, 64'hF8, 0, 3'b000);
    apply("add_ovf2", ALU_ADD, PMAX, 64'd1, 1, NMIN, 1, 3'b011);
    #2;
    rst_n = 0;
    #1;
    check("async_reset", {61'd0, bus.flags}, 64'd0);
    apply("in_reset", ALU_ADD, 64'd2, 64'd3, 1, 64'd5, 0, 3'b000);
    rst_n = 1;
    apply("post_reset_hold", ALU_SUB, 64'd3, 64'd10, 0, 64'hFFFF_FFFF_FFFF_FFF9, 0, 3'b000);
    apply("post_reset_set", ALU_SUB, 64'd3, 64'd10, 1, 64'hFFFF_FFFF_FFFF_FFF9, 0, 3'b010);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
